mem_spm_ctrl: RTL and testbench

MEM-stage initiator for the scratch-pad memory's MEM port. It accepts one load/store request at a time from the MEM stage and checks alignment and address range. It drives the SPM strobe, address, read/write and write-data lines, and returns formatted load data or a completion pulse. Byte and halfword stores are implemented as read-modify-write, because the SPM port writes whole words only.

---
 rtl/mem_spm_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_mem_spm_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_spm_ctrl.sv
// mem_spm_ctrl: MEM-stage initiator for the scratch-pad memory MEM port.
// Accepts one load/store at a time, checks alignment and window range,
// drives the SPM strobe/address/rw/write-data lines and returns formatted
// load data or a completion pulse. Sub-word stores are read-modify-write
// because the SPM port only writes whole words.
module mem_spm_ctrl #(
    parameter int unsigned SPM_ADDR_W = 12,
    parameter logic [31:0] SPM_BASE   = 32'h2000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req,
    input  logic [2:0]            i_req_op,
    input  logic [31:0]           i_req_addr,
    input  logic [31:0]           i_req_wr_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [31:0]           o_rd_data,
    output logic [SPM_ADDR_W-1:0] o_spm_addr,
    output logic                  o_spm_as_,
    output logic                  o_spm_rw,
    output logic [31:0]           o_spm_wr_data,
    input  logic [31:0]           i_spm_rd_data
);

    // SPM read/write line encoding
    localparam logic SPM_READ  = 1'b1;
    localparam logic SPM_WRITE = 1'b0;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_READ_WAIT = 3'd2,
        S_RMW_READ  = 3'd3,
        S_RMW_WAIT  = 3'd4,
        S_WRITE     = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // Request fields captured at acceptance; the transaction in flight
    // never looks at the live request inputs again.
    op_t                   r_op;
    logic [1:0]            r_lane;
    logic [31:0]           r_st_data;

    logic                  r_done;
    logic                  r_err;
    logic [31:0]           r_rd_data;
    logic [SPM_ADDR_W-1:0] r_spm_addr;
    logic                  r_spm_as_n;
    logic                  r_spm_rw;
    logic [31:0]           r_spm_wr_data;

    op_t                   w_req_op;
    logic                  w_accept;
    logic                  w_is_word;
    logic                  w_is_half;
    logic                  w_is_load;
    logic                  w_misalign;
    logic                  w_out_of_range;
    logic                  w_req_bad;
    logic                  w_strobe_nxt;

    // Lane-extract a loaded word and sign/zero-extend according to the op.
    function automatic logic [31:0] fmt_load(input op_t op, input logic [1:0] lane,
                                             input logic [31:0] word);
        logic [15:0] half;
        logic [7:0]  byte_v;
        half = lane[1] ? word[31:16] : word[15:0];
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        case (op)
            OP_LH:   fmt_load = {{16{half[15]}}, half};
            OP_LHU:  fmt_load = {16'h0000, half};
            OP_LB:   fmt_load = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  fmt_load = {24'h00_0000, byte_v};
            default: fmt_load = word;
        endcase
    endfunction

    // Merge store lanes into the word read back from the SPM.
    function automatic logic [31:0] merge_store(input op_t op, input logic [1:0] lane,
                                                input logic [31:0] old_word,
                                                input logic [31:0] data);
        logic [31:0] res;
        res = old_word;
        case (op)
            OP_SB: begin
                case (lane)
                    2'd0:    res[7:0]   = data[7:0];
                    2'd1:    res[15:8]  = data[7:0];
                    2'd2:    res[23:16] = data[7:0];
                    default: res[31:24] = data[7:0];
                endcase
            end
            OP_SH: begin
                if (lane[1]) res[31:16] = data[15:0];
                else         res[15:0]  = data[15:0];
            end
            default: res = data;
        endcase
        return res;
    endfunction

    // Request decode and error classification, only meaningful in IDLE.
    always_comb begin
        w_req_op       = op_t'(i_req_op);
        w_accept       = (r_state == S_IDLE) && i_req;
        w_is_word      = (w_req_op == OP_LW) || (w_req_op == OP_SW);
        w_is_half      = (w_req_op == OP_LH) || (w_req_op == OP_LHU) || (w_req_op == OP_SH);
        w_is_load      = (i_req_op <= 3'b100);
        w_misalign     = (w_is_word && (i_req_addr[1:0] != 2'b00)) ||
                         (w_is_half && i_req_addr[0]);
        w_out_of_range = (i_req_addr[31:SPM_ADDR_W+2] != SPM_BASE[31:SPM_ADDR_W+2]);
        w_req_bad      = w_misalign || w_out_of_range;
    end

    // Next-state decode; the strobe is asserted in every state that talks to the SPM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    if (w_req_bad)             w_state_nxt = S_DONE;
                    else if (w_is_load)        w_state_nxt = S_READ;
                    else if (w_req_op == OP_SW) w_state_nxt = S_WRITE;
                    else                       w_state_nxt = S_RMW_READ;
                end
            end
            S_READ:      w_state_nxt = S_READ_WAIT;
            S_READ_WAIT: w_state_nxt = S_DONE;
            S_RMW_READ:  w_state_nxt = S_RMW_WAIT;
            S_RMW_WAIT:  w_state_nxt = S_WRITE;
            S_WRITE:     w_state_nxt = S_DONE;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
        w_strobe_nxt = (w_state_nxt == S_READ) || (w_state_nxt == S_RMW_READ) ||
                       (w_state_nxt == S_WRITE);
    end

    // State register plus Moore output flops, loaded from the next state so
    // each output is visible exactly while the FSM sits in the matching state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_rd_data     <= 32'h0000_0000;
            r_spm_addr    <= '0;
            r_spm_as_n    <= 1'b1;
            r_spm_rw      <= SPM_READ;
            r_spm_wr_data <= 32'h0000_0000;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= (w_state_nxt == S_DONE);
            r_err      <= w_accept && w_req_bad;
            r_spm_as_n <= !w_strobe_nxt;
            r_spm_rw   <= (w_state_nxt == S_WRITE) ? SPM_WRITE : SPM_READ;
            if (w_accept && !w_req_bad) begin
                r_spm_addr <= i_req_addr[SPM_ADDR_W+1:2];
                if (w_req_op == OP_SW) r_spm_wr_data <= i_req_wr_data;
            end
            if (r_state == S_READ_WAIT) r_rd_data <= fmt_load(r_op, r_lane, i_spm_rd_data);
            if (r_state == S_RMW_WAIT)
                r_spm_wr_data <= merge_store(r_op, r_lane, i_spm_rd_data, r_st_data);
        end
    end

    // Latch the request fields when a request is accepted.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_op      <= w_req_op;
            r_lane    <= i_req_addr[1:0];
            r_st_data <= i_req_wr_data;
        end
    end

    // busy is the only combinational output: decoded straight from the state.
    always_comb begin
        o_busy = (r_state != S_IDLE);
    end

    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_rd_data     = r_rd_data;
    assign o_spm_addr    = r_spm_addr;
    assign o_spm_as_     = r_spm_as_n;
    assign o_spm_rw      = r_spm_rw;
    assign o_spm_wr_data = r_spm_wr_data;

endmodule

// File: tb/tb_mem_spm_ctrl.sv
// Testbench for mem_spm_ctrl: SPM behavioural model, directed requests with
// hand-computed results, and a scoreboard monitor checking every done pulse.
module tb_mem_spm_ctrl;

    localparam int   AW       = 12;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                           LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic [2:0]    op = 3'b000;
    logic [31:0]   addr = 32'h0;
    logic [31:0]   wd = 32'h0;
    logic          o_busy, o_done, o_err, o_spm_as_, o_spm_rw;
    logic [31:0]   o_rd_data, o_spm_wr_data;
    logic [AW-1:0] o_spm_addr;
    logic [31:0]   spm_rd_data = 32'h0;

    mem_spm_ctrl #(.SPM_ADDR_W(AW), .SPM_BASE(32'h2000_0000)) dut (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_req_op(op),
        .i_req_addr(addr), .i_req_wr_data(wd),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rd_data(o_rd_data),
        .o_spm_addr(o_spm_addr), .o_spm_as_(o_spm_as_), .o_spm_rw(o_spm_rw),
        .o_spm_wr_data(o_spm_wr_data), .i_spm_rd_data(spm_rd_data)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mem [0:4095];
    int          n_rd = 0, n_wr = 0, last_rd_cyc = -1, last_wr_cyc = -1;
    logic [31:0] last_wr_data = 32'h0;

    typedef struct { int cyc; logic err; logic [31:0] rd; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endfunction

    // SPM model: registered read data, whole-word writes, strobe bookkeeping
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8899_AABB;
        end else if (!o_spm_as_) begin
            if (o_spm_rw == RW_WRITE) begin
                mem[o_spm_addr] <= o_spm_wr_data;
                n_wr            <= n_wr + 1;
                last_wr_cyc     <= cyc;
                last_wr_data    <= o_spm_wr_data;
            end else begin
                spm_rd_data <= mem[o_spm_addr];
                n_rd        <= n_rd + 1;
                last_rd_cyc <= cyc;
            end
        end
    end

    // Scoreboard monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (o_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("err", {31'd0, o_err}, {31'd0, mon_e.err});
                check("rd_data", o_rd_data, mon_e.rd);
            end
        end
    end

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (o_busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (o_busy) check({tag, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic do_req(input logic [2:0] r_op, input logic [31:0] r_addr,
                          input logic [31:0] r_wd, input int lat, input logic e_err,
                          input logic [31:0] e_rd, output int n);
        @(negedge clk);
        wait_idle("pre");
        n = cyc;
        sb.push_back('{cyc + lat, e_err, e_rd});
        req = 1'b1; op = r_op; addr = r_addr; wd = r_wd;
        @(negedge clk);
        req = 1'b0; op = 3'b111; addr = 32'hFFFF_FFFF; wd = 32'h5A5A_5A5A;
        wait_idle("post");
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
        check({tag, "_done"},  {31'd0, o_done}, 32'd0);
        check({tag, "_err"},   {31'd0, o_err}, 32'd0);
        check({tag, "_rd"},    o_rd_data, 32'h0);
        check({tag, "_as"},    {31'd0, o_spm_as_}, 32'd1);
        check({tag, "_rw"},    {31'd0, o_spm_rw}, {31'd0, RW_READ});
        check({tag, "_addr"},  {20'd0, o_spm_addr}, 32'd0);
        check({tag, "_wdata"}, o_spm_wr_data, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, r0, w0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;

        // Loads from the preloaded word 0x2000_0010 = 0x8899_AABB
        r0 = n_rd; w0 = n_wr;
        do_req(LW, 32'h2000_0010, 32'h0, 3, 1'b0, 32'h8899_AABB, n);
        check("lw_reads", 32'(n_rd - r0), 32'd1);
        check("lw_rd_cyc", 32'(last_rd_cyc), 32'(n + 1));
        check("lw_writes", 32'(n_wr - w0), 32'd0);
        do_req(LB,  32'h2000_0013, 32'h0, 3, 1'b0, 32'hFFFF_FF88, n);
        do_req(LBU, 32'h2000_0013, 32'h0, 3, 1'b0, 32'h0000_0088, n);
        do_req(LH,  32'h2000_0010, 32'h0, 3, 1'b0, 32'hFFFF_AABB, n);
        do_req(LHU, 32'h2000_0012, 32'h0, 3, 1'b0, 32'h0000_8899, n);

        // SB read-modify-write into byte lane 1
        r0 = n_rd; w0 = n_wr;
        do_req(SB, 32'h2000_0011, 32'h0000_0011, 4, 1'b0, 32'h0000_8899, n);
        check("sb_reads", 32'(n_rd - r0), 32'd1);
        check("sb_rd_cyc", 32'(last_rd_cyc), 32'(n + 1));
        check("sb_writes", 32'(n_wr - w0), 32'd1);
        check("sb_wr_cyc", 32'(last_wr_cyc), 32'(n + 3));
        check("sb_wr_data", last_wr_data, 32'h8899_11BB);
        do_req(LW, 32'h2000_0010, 32'h0, 3, 1'b0, 32'h8899_11BB, n);

        // Error cases: no strobe, rd_data held
        r0 = n_rd; w0 = n_wr;
        do_req(SH, 32'h2000_0011, 32'h0, 1, 1'b1, 32'h8899_11BB, n);
        do_req(LW, 32'h3000_0000, 32'h0, 1, 1'b1, 32'h8899_11BB, n);
        do_req(LW, 32'h2000_0012, 32'h0, 1, 1'b1, 32'h8899_11BB, n);
        check("err_no_reads", 32'(n_rd - r0), 32'd0);
        check("err_no_writes", 32'(n_wr - w0), 32'd0);

        // SW with req held through N+2: second request must be ignored
        @(negedge clk);
        wait_idle("sw");
        n = cyc; r0 = n_rd; w0 = n_wr;
        sb.push_back('{n + 2, 1'b0, 32'h8899_11BB});
        req = 1'b1; op = SW; addr = 32'h2000_0020; wd = 32'hDEAD_BEEF;
        @(negedge clk);
        op = LW; addr = 32'h2000_0010; wd = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("sw_busy_n3", {31'd0, o_busy}, 32'd0);
        req = 1'b0;
        repeat (3) @(negedge clk);
        check("sw_writes", 32'(n_wr - w0), 32'd1);
        check("sw_reads", 32'(n_rd - r0), 32'd0);
        check("sw_wr_cyc", 32'(last_wr_cyc), 32'(n + 1));
        check("sw_wr_data", last_wr_data, 32'hDEAD_BEEF);
        do_req(LW, 32'h2000_0020, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, n);

        // SH into the upper half, then sub-word reads of the merged word
        do_req(SH, 32'h2000_0022, 32'hAAAA_1234, 4, 1'b0, 32'hDEAD_BEEF, n);
        check("sh_wr_data", last_wr_data, 32'h1234_BEEF);
        do_req(LH, 32'h2000_0022, 32'h0, 3, 1'b0, 32'h0000_1234, n);
        do_req(LB, 32'h2000_0021, 32'h0, 3, 1'b0, 32'hFFFF_FFBE, n);
        do_req(LW, 32'h2000_0020, 32'h0, 3, 1'b0, 32'h1234_BEEF, n);

        // Reset during RMW_WAIT of an SB: no write, no done
        @(negedge clk);
        wait_idle("rst_sb");
        w0 = n_wr;
        req = 1'b1; op = SB; addr = 32'h2000_0010; wd = 32'h0000_0055;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("rmw_wait_busy", {31'd0, o_busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        check("midrst_no_write", 32'(n_wr - w0), 32'd0);
        do_req(LW, 32'h2000_0010, 32'h0, 3, 1'b0, 32'h8899_11BB, n);

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
